// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset vector and fetch FSM states.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory request/ack plus decoder valid/ready and jump inputs.
interface pc_fetch_ctrl_if
  import cpu_pkg::*;
;

  // imem: req/addr held until the ack cycle; ack is meaningful only while req=1.
  // decode: instr_out is held while valid=1 and ready=0; valid&ready is the consume cycle,
  // which is also the only cycle jump_en/jump_addr are looked at.
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_data;
  logic [WORD_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_en;
  logic [WORD_W-1:0] jump_addr;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid,
    input  imem_ack, imem_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid,
    output imem_ack, imem_data, instr_ready, jump_en, jump_addr
  );

endinterface

// File: rtl/Inc16.sv
// 16-bit incrementer shared by the PC and the retire counter.
module Inc16 (
  input  logic [15:0] a,
  output logic [15:0] y,
  output logic        co
);

  assign {co, y} = {1'b0, a} + 17'd1;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and single-outstanding instruction fetch controller.
// Optional macro PC_WRAP_TRAP_EN: a sequential step past 16'hFFFF halts instead of wrapping.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  pc_fetch_ctrl_if.master   bus,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] retire_count,
  output logic              halted,
  output fetch_state_t      state_dbg
);

  fetch_state_t      state, state_next;
  logic              fetch_done, consume, trap;
  logic              req_d, valid_d;
  logic [WORD_W-1:0] pc_inc, retire_inc, pc_d;
  logic              unused_pc_co, unused_retire_co;

  Inc16 u_pc_inc     (.a(pc),           .y(pc_inc),     .co(unused_pc_co));
  Inc16 u_retire_inc (.a(retire_count), .y(retire_inc), .co(unused_retire_co));

  assign fetch_done = (state == FETCH) && bus.imem_ack;
  assign consume    = (state == HOLD) && bus.instr_ready;

`ifdef PC_WRAP_TRAP_EN
  assign trap = consume && !bus.jump_en && (pc == {WORD_W{1'b1}});
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RESET: state_next = FETCH;
      FETCH: if (fetch_done) state_next = HOLD;
      HOLD:  if (consume) state_next = trap ? HALT : FETCH;
      HALT:  state_next = HALT;
      default: state_next = RESET;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing combinational reaches a port.
  always_comb begin
    req_d   = (state_next == FETCH);
    valid_d = (state_next == HOLD);
    pc_d    = pc;
    if (consume) begin
      if (bus.jump_en) pc_d = bus.jump_addr;
      else if (!trap)  pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc              <= RESET_VECTOR;
      bus.imem_req    <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      retire_count    <= '0;
    end else begin
      pc              <= pc_d;
      bus.imem_req    <= req_d;
      bus.instr_valid <= valid_d;
      if (fetch_done) bus.instr_out <= bus.imem_data;
      if (consume)    retire_count  <= retire_inc;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  halted <= 1'b0;
    else if (trap) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  assign bus.imem_addr = pc;
  assign state_dbg     = state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected fetch addresses and instructions are queued by the driver
// and checked by a monitor on each memory handshake and each decoder consume.
module tb_pc_fetch_ctrl;
  import cpu_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [15:0]  pc, retire_count;
  logic         halted;
  fetch_state_t state_dbg;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .pc           (pc),
    .retire_count (retire_count),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  int total = 0;
  int passed = 0;
  int exp_retire = 0;
  logic [15:0] addr_q[$];
  logic [15:0] instr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && bus.imem_req && bus.imem_ack) begin
      if (addr_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_fetch: addr %0h with no expected entry", bus.imem_addr);
      end else chk("imem_addr", bus.imem_addr, addr_q.pop_front());
    end
    if (reset_n && bus.instr_valid && bus.instr_ready) begin
      if (instr_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_consume: instr %0h with no expected entry", bus.instr_out);
      end else chk("instr_out", bus.instr_out, instr_q.pop_front());
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},        pc, 16'h0000);
    chk({tag, "_req"},       bus.imem_req, 1'b0);
    chk({tag, "_valid"},     bus.instr_valid, 1'b0);
    chk({tag, "_instr_out"}, bus.instr_out, 16'h0000);
    chk({tag, "_retire"},    retire_count, 16'h0000);
    chk({tag, "_halted"},    halted, 1'b0);
    chk({tag, "_state"},     state_dbg, RESET);
  endtask

  // driver: one instruction through memory and decoder; called at #1 after a rising edge
  task automatic do_instr(input logic [15:0] a, input int ack_dly, input int rdy_dly,
                          input logic jen, input logic [15:0] jaddr, input logic exp_trap);
    logic [15:0] d;
    int n;
    d = a ^ 16'hA5A5;
    addr_q.push_back(a);
    instr_q.push_back(d);
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.imem_req) begin
      total++;
      $display("FAIL req_timeout: imem_req never rose for addr %0h", a);
      void'(addr_q.pop_back());
      void'(instr_q.pop_back());
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      bus.jump_en = 1'b1;
      bus.jump_addr = 16'hDEAD;
      @(posedge clk); #1;
      chk("req_held", bus.imem_req, 1'b1);
      chk("addr_held", bus.imem_addr, a);
      chk("valid_low_in_fetch", bus.instr_valid, 1'b0);
    end
    bus.jump_en = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_data = bus.imem_addr ^ 16'hA5A5;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    chk("valid_after_ack", bus.instr_valid, 1'b1);
    chk("req_drop_after_ack", bus.imem_req, 1'b0);
    chk("state_hold", state_dbg, HOLD);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.jump_en = 1'b1;
      bus.jump_addr = 16'hBEEF;
      @(posedge clk); #1;
      chk("valid_held", bus.instr_valid, 1'b1);
      chk("instr_held", bus.instr_out, d);
      chk("no_req_in_hold", bus.imem_req, 1'b0);
    end
    bus.instr_ready = 1'b1;
    bus.jump_en = jen;
    bus.jump_addr = jaddr;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    exp_retire = (exp_retire + 1) & 16'hFFFF;
    chk("retire_count", retire_count, exp_retire);
    chk("valid_drop_after_consume", bus.instr_valid, 1'b0);
    chk("req_after_consume", bus.imem_req, !exp_trap);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 16'h0000);
    chk("state_fetch", state_dbg, FETCH);

    // zero-wait memory, always-ready decoder
    for (int i = 0; i < 4; i++) do_instr(16'(i), 0, 0, 1'b0, 16'h0000, 1'b0);
    chk("retire_after_4", retire_count, 16'd4);

    do_instr(16'h0004, 3, 0, 1'b0, 16'h0000, 1'b0);
    do_instr(16'h0005, 0, 5, 1'b0, 16'h0000, 1'b0);

    // jumps
    do_instr(16'h0006, 0, 0, 1'b1, 16'h0010, 1'b0);
    do_instr(16'h0010, 1, 0, 1'b1, 16'h1234, 1'b0);
    do_instr(16'h1234, 0, 0, 1'b0, 16'h0000, 1'b0);
    do_instr(16'h1235, 0, 0, 1'b1, 16'hFFFF, 1'b0);

`ifdef PC_WRAP_TRAP_EN
    do_instr(16'hFFFF, 0, 0, 1'b0, 16'h0000, 1'b1);
    chk("trap_halted", halted, 1'b1);
    chk("trap_pc", pc, 16'hFFFF);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("halt_no_req", bus.imem_req, 1'b0);
      chk("halt_no_valid", bus.instr_valid, 1'b0);
    end
    bus.imem_ack = 1'b0;
    chk("state_halt", state_dbg, HALT);
`else
    do_instr(16'hFFFF, 0, 0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_not_halted", halted, 1'b0);
    chk("wrap_pc", pc, 16'h0000);
    do_instr(16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0);
`endif

    // reset mid-fetch with an ack that arrives during and right after reset
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h7777;
    #2;
    chk_reset_vals("mid_rst");
    exp_retire = 0;
    @(posedge clk); #1;
    chk("rst_hold_req", bus.imem_req, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    chk("stale_ack_valid", bus.instr_valid, 1'b0);
    chk("stale_ack_instr", bus.instr_out, 16'h0000);
    chk("restart_req", bus.imem_req, 1'b1);
    chk("restart_addr", bus.imem_addr, 16'h0000);
    do_instr(16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_drained", addr_q.size(), 0);
    chk("instr_q_drained", instr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
